// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame geometry and keyboard command bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_REQUEST,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_e;

   localparam int         PS2_FRAME_BITS = 11;
   localparam logic [7:0] PS2_CMD_LEDS   = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_ACK        = 8'hFA;

   // Odd parity: the parity bit makes the total count of ones in data+parity odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 2-FF synchronizer for an asynchronous PS/2 pin with falling-edge detect on the synchronized level.
module ps2_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic level,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = pin;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // Reset to 1 (idle-high line) so leaving reset never looks like an edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign fall  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: request-to-send, clocked-out frame, ACK check and timeout.
module ps2_transmitter
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clock,
   input  logic       ps2_data,
   output logic       ps2_clock_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]       STOP_EDGE = 4'(PS2_FRAME_BITS - 2);

   ps2_tx_state_e    state_q, state_d;
   logic [9:0]       shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic             clock_oe_q, clock_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             dmeta_q, dmeta_d;
   logic             dsync_q, dsync_d;
   logic             clk_sync, clk_fall;
   logic             fin_ok, fin_err;

   ps2_sync_edge u_clk_sync (
      .clk   (clk),
      .reset (reset),
      .pin   (ps2_clock),
      .level (clk_sync),
      .fall  (clk_fall)
   );

   always_comb begin
      dmeta_d    = ps2_data;
      dsync_d    = dmeta_q;
      state_d    = state_q;
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      bit_cnt_d  = bit_cnt_q;
      clock_oe_d = clock_oe_q;
      data_oe_d  = data_oe_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      fin_ok     = 1'b0;
      fin_err    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (tx_start) begin
               shift_d    = {1'b1, odd_parity(tx_data), tx_data};
               cnt_d      = '0;
               bit_cnt_d  = '0;
               clock_oe_d = 1'b1;
               data_oe_d  = 1'b0;
               ready_d    = 1'b0;
               busy_d     = 1'b1;
               state_d    = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d     = '0;
               data_oe_d = 1'b1;
               state_d   = ST_REQUEST;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_REQUEST: begin
            // Releasing the clock while data stays low is the start bit.
            clock_oe_d = 1'b0;
            cnt_d      = '0;
            state_d    = ST_SEND;
         end
         ST_SEND, ST_ACK, ST_WAIT_IDLE: begin
            cnt_d = clk_fall ? '0 : cnt_q + 1'b1;
            if (!clk_fall && cnt_q == TO_LAST) fin_err = 1'b1;
            if (state_q == ST_SEND && clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = {1'b1, shift_q[9:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == STOP_EDGE) state_d = ST_ACK;
            end
            if (state_q == ST_ACK && clk_fall) begin
               if (dsync_q) fin_err = 1'b1;
               else         state_d = ST_WAIT_IDLE;
            end
            if (state_q == ST_WAIT_IDLE && clk_sync && dsync_q) fin_ok = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      // A clean finish wins over a coincident timeout, so done and error stay exclusive.
      if (fin_ok || fin_err) begin
         state_d    = ST_IDLE;
         clock_oe_d = 1'b0;
         data_oe_d  = 1'b0;
         ready_d    = 1'b1;
         busy_d     = 1'b0;
         done_d     = fin_ok;
         error_d    = ~fin_ok;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '1;
         cnt_q      <= '0;
         bit_cnt_q  <= '0;
         clock_oe_q <= 1'b0;
         data_oe_q  <= 1'b0;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         dmeta_q    <= 1'b1;
         dsync_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         clock_oe_q <= clock_oe_d;
         data_oe_q  <= data_oe_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         dmeta_q    <= dmeta_d;
         dsync_q    <= dsync_d;
      end
   end

   assign ps2_clock_oe = clock_oe_q;
   assign ps2_data_oe  = data_oe_q;
   assign tx_ready     = ready_q;
   assign tx_busy      = busy_q;
   assign tx_done      = done_q;
   assign tx_error     = error_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: open-drain bus, keyboard device model and a frame-level reference model.
module tb_ps2_transmitter;

   localparam int INH = 8;
   localparam int TO  = 200;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clock, ps2_data;
   logic       ps2_clock_oe, ps2_data_oe;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_ready, tx_busy, tx_done, tx_error;
   logic       dev_clk_low, dev_data_low;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen = 0;
   int err_seen  = 0;
   int both_seen = 0;

   ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .ps2_clock    (ps2_clock),
      .ps2_data     (ps2_data),
      .ps2_clock_oe (ps2_clock_oe),
      .ps2_data_oe  (ps2_data_oe),
      .tx_data      (tx_data),
      .tx_start     (tx_start),
      .tx_ready     (tx_ready),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done),
      .tx_error     (tx_error)
   );

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clock = ~ps2_clock_oe & ~dev_clk_low;
   assign ps2_data  = ~ps2_data_oe  & ~dev_data_low;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done)              done_seen++;
      if (tx_error)             err_seen++;
      if (tx_done && tx_error)  both_seen++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] exp_frame(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   // Accept, then check inhibit length, the request cycle and the start-bit drive.
   task automatic start_req(input logic [7:0] b);
      int n_inh;
      @(negedge clk);
      chk("ready_pre", tx_ready, 1);
      tx_data  = b;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      chk("busy_after_accept", {tx_busy, tx_ready}, 2'b10);
      n_inh = 0;
      while (ps2_clock_oe && !ps2_data_oe && n_inh < 100) begin
         n_inh++;
         @(negedge clk);
      end
      chk("inhibit_len", n_inh, INH);
      chk("request", {ps2_clock_oe, ps2_data_oe}, 2'b11);
      @(negedge clk);
      chk("start_drive", {ps2_clock_oe, ps2_data_oe}, 2'b01);
   endtask

   task automatic dev_frame(input bit ack, input int inj, input int rst_e, output logic [10:0] cap);
      cap = '0;
      cyc(20);
      cap[0] = ps2_data;
      for (int e = 1; e <= 11; e++) begin
         if (e == 11 && ack) begin
            dev_data_low = 1'b1;
            cyc(4);
         end
         dev_clk_low = 1'b1;
         if (e == inj) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
         end
         cyc(1);
         tx_start = 1'b0;
         if (e == rst_e) begin
            reset = 1'b1;
            cyc(1);
            reset = 1'b0;
            chk("reset_midframe",
                {ps2_clock_oe, ps2_data_oe, tx_ready, tx_busy, tx_done, tx_error}, 6'b001000);
            dev_clk_low  = 1'b0;
            dev_data_low = 1'b0;
            return;
         end
         cyc(19);
         dev_clk_low = 1'b0;
         if (e <= 10) cap[e] = ps2_data;
         cyc(20);
      end
      dev_data_low = 1'b0;
   endtask

   task automatic run(input logic [7:0] b, input bit ack, input int inj, input int rst_e);
      logic [10:0] cap, ef;
      int d0, e0;
      ef = exp_frame(b);
      d0 = done_seen;
      e0 = err_seen;
      start_req(b);
      dev_frame(ack, inj, rst_e, cap);
      if (rst_e != 0) begin
         cyc(250);
         chk("rst_no_done", done_seen - d0, 0);
         chk("rst_no_err", err_seen - e0, 0);
         chk("rst_idle", {ps2_clock_oe, ps2_data_oe, tx_ready, tx_busy}, 4'b0010);
      end else begin
         cyc(30);
         chk("frame", cap, ef);
         chk("parity", cap[9], ef[9]);
         chk("done_cnt", done_seen - d0, ack ? 1 : 0);
         chk("err_cnt", err_seen - e0, ack ? 0 : 1);
         chk("idle_after", {ps2_clock_oe, ps2_data_oe, tx_ready, tx_busy}, 4'b0010);
      end
   endtask

   task automatic timeout_test(input logic [7:0] b);
      int k, d0, e0;
      d0 = done_seen;
      e0 = err_seen;
      start_req(b);
      k = 0;
      while (k < 400) begin
         @(negedge clk);
         k++;
         if (tx_error) break;
      end
      chk("timeout_cycles", k, TO);
      chk("timeout_lines", {ps2_clock_oe, ps2_data_oe, tx_ready}, 3'b001);
      cyc(5);
      chk("timeout_err_cnt", err_seen - e0, 1);
      chk("timeout_no_done", done_seen - d0, 0);
   endtask

   initial begin
      logic [7:0] rb;
      bit ra;
      reset        = 1'b1;
      tx_start     = 1'b0;
      tx_data      = 8'h00;
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      cyc(3);
      chk("rst_clock_oe", ps2_clock_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_ready", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_error", tx_error, 0);
      reset = 1'b0;
      cyc(5);

      run(8'hED, 1'b1, 0, 0);
      run(8'h00, 1'b1, 0, 0);
      run(8'hFF, 1'b1, 0, 0);
      run(8'h01, 1'b1, 0, 0);
      run(8'hED, 1'b0, 0, 0);
      timeout_test(8'hA5);
      run(8'hED, 1'b1, 3, 0);
      run(8'hED, 1'b1, 0, 5);
      for (int i = 0; i < 6; i++) begin
         rb = 8'($urandom_range(0, 255));
         ra = ($urandom_range(0, 3) != 0);
         run(rb, ra, 0, 0);
      end
      chk("never_both", both_seen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ps2_transmitter.md
# ps2_transmitter

Host-to-device PS/2 transmitter for the DE1-SoC PS/2 port: sends one command byte (LED set `8'hED`, reset `8'hFF`, typematic, …) to the keyboard. It sits beside `ps2_controller`, which stays the receive path, on the same open-drain PS/2 clock and data lines. The block runs the host request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, checks the device ACK, and reports done or error to the command logic.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 5000: `clk` cycles the clock line is held low before request-to-send (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 750000: maximum `clk` cycles allowed between device clock falling edges, and for final line release (15 ms).

Ports:
- `clk`  in  1  system clock, 50 MHz; the only clock.
- `reset`  in  1  synchronous, active-high.
- `ps2_clock`  in  1  PS/2 clock pin sense, asynchronous.
- `ps2_data`  in  1  PS/2 data pin sense, asynchronous.
- `ps2_clock_oe`  out  1  1 = pull clock line low; 0 = release.
- `ps2_data_oe`  out  1  1 = pull data line low; 0 = release.
- `tx_data`  in  8  byte to send; sampled on accept.
- `tx_start`  in  1  request; accepted only when `tx_ready`=1.
- `tx_ready`  out  1  idle; a `tx_start` is accepted this cycle.
- `tx_busy`  out  1  transfer in progress; the receive path ignores frames while this is 1.
- `tx_done`  out  1  1-cycle pulse: frame ACKed and lines idle.
- `tx_error`  out  1  1-cycle pulse: missing ACK or timeout.

## Operation
- `ps2_clock` and `ps2_data` each pass a 2-FF synchronizer. A falling edge of `ps2_clock` (`fall`) is registered as previous synchronized value = 1 and current = 0.
- Frame register: a 10-bit shift register `{1'b1 stop, parity, tx_data}`. Parity is odd: `~^tx_data`.
- Data pin drive: `ps2_data_oe = ~bit` while driving. A 1 is sent by releasing the line.

States:
- IDLE: both `oe`=0, `tx_ready`=1. On `tx_start`, load the shift register, clear the counter, go to INHIBIT.
- INHIBIT: `ps2_clock_oe`=1. After INHIBIT_CYCLES cycles go to REQUEST.
- REQUEST: `ps2_clock_oe`=1 and `ps2_data_oe`=1 for exactly 1 cycle, then go to SEND with `ps2_clock_oe`=0 and `ps2_data_oe`=1. The start bit is driven from here.
- SEND: on each `fall`, shift and drive the next bit. Edges 1–8 carry data bits 0–7, LSB first. Edge 9 carries parity. Edge 10 carries the stop bit (line released).
- ACK: on edge 11, sample synchronized data. 0 → go to WAIT_IDLE. 1 → pulse `tx_error`, go to IDLE.
- WAIT_IDLE: wait until synchronized clock and data are both 1, pulse `tx_done`, go to IDLE.

Timeout:
- The counter is reused as a timeout counter in SEND, ACK and WAIT_IDLE. It clears on every `fall`.
- When it reaches TIMEOUT_CYCLES, release both lines, pulse `tx_error`, and go to IDLE.

Boundary rules:
- `tx_start` while not ready is ignored; no queueing.
- `tx_done` and `tx_error` are never asserted together.
- Reset mid-frame: the next cycle is IDLE with both `oe`=0. No pulse is issued and the partial frame is abandoned.

## Timing
- Reset values: `ps2_clock_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_error`=0.
- Accept → `ps2_clock_oe`=1 on the next cycle, held for exactly INHIBIT_CYCLES cycles, plus the 1 REQUEST cycle with data also low.
- Pin falling edge → `ps2_data_oe` update after 3 `clk` cycles (2 sync + 1 register). This is well inside the device's ~40 µs low phase.
- `tx_busy` = ~`tx_ready`. It goes high the cycle after accept and low in the cycle the done/error pulse is issued.
- All outputs are registered.

## Structure
- Shared package `ps2_pkg`: state enum, `PS2_FRAME_BITS = 11`, and command constants (`PS2_CMD_LEDS = 8'hED`, `PS2_CMD_RESET = 8'hFF`, `PS2_ACK = 8'hFA`).
- One sub-module, `ps2_sync_edge`: 2-FF synchronizer plus falling-edge detect. It is also usable by `ps2_controller`.
- The counter is sized `$clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1)`.

## Test plan
Bench setup: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200. A device model generates 11 clocks with a 20-cycle half period, samples data on rising edges, and drives the ACK low on edge 11.
- Send `8'hED`: clock_oe high exactly 8 cycles, then a 1-cycle request. The device captures start 0, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Then `tx_done` pulses once and `tx_error`=0.
- Send `8'h00`, `8'hFF`, `8'h01`: captured parity is 1, 1, 0 respectively. All complete with `tx_done`.
- Device holds data high at edge 11 (no ACK) → `tx_error` pulse, lines released, `tx_ready`=1.
- Device never clocks after request → `tx_error` exactly 200 cycles after SEND entry, both `oe`=0.
- `tx_start` pulsed with `8'h55` mid-frame of `8'hED` → ignored; only `8'hED` is captured. Then `reset` asserted at edge 5 → next cycle both `oe`=0, `tx_ready`=1, no done/error pulse.
